// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the convolution layer controller:
//     - state_t       : controller FSM state encoding
//     - calc_nw       : number of weight words for a layer
//     - calc_npix     : number of input pixels per frame
//     - calc_out_dim  : output edge length for one image dimension
//     - addr_width    : address/counter width able to index n items (min 1)
// ----------------------------------------------------------------------------
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int calc_nw(input int num_filters, input int in_channel,
                                 input int kernel_size);
    return num_filters * in_channel * kernel_size * kernel_size;
  endfunction

  function automatic int calc_npix(input int img_width, input int img_height);
    return img_width * img_height;
  endfunction

  function automatic int calc_out_dim(input int img_dim, input int kernel_size,
                                      input int padding, input int stride);
    return (img_dim + 2 * padding - kernel_size) / stride + 1;
  endfunction

  // A zero-width vector is illegal, so a single-entry space still gets 1 bit.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_addr_counter.sv
// ----------------------------------------------------------------------------
// conv_addr_counter
//   Up-counter used for memory read addresses. Counts on enable, wraps back
//   to zero after MAX, and flags when the current value is MAX.
//
//   Ports:
//     clk     in   clock
//     rst_n   in   async active-low reset (count -> 0)
//     clear   in   synchronous clear to 0 (wins over enable)
//     enable  in   advance by one this cycle
//     count   out  current address [WIDTH-1:0]
//     at_max  out  high while count == MAX
// ----------------------------------------------------------------------------
module conv_addr_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign at_max = (count == MAX_V);

  // Wrapping at MAX leaves the counter at zero once a full sweep finishes,
  // so the next pass starts from a known address even without a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_max ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_layer_ctrl.sv
// ----------------------------------------------------------------------------
// conv_layer_ctrl
//   Sequences one convolution layer pass: loads all weight words into the
//   conv engine, streams the input frame pixel by pixel (honouring
//   downstream back-pressure), then waits for the engine to return every
//   output before signalling completion.
//
//   Ports:
//     clk            in   clock
//     rst_n          in   async active-low reset
//     start          in   begin a pass (only honoured in IDLE)
//     busy           out  high in every state except IDLE
//     done           out  one-cycle pulse at pass end
//     error          out  sticky fault (overflow or drain timeout)
//     wgt_rd_en      out  weight memory read strobe
//     wgt_rd_addr    out  weight memory address
//     wgt_load_en    out  weight word valid to conv engine
//     wgt_load_last  out  marks the final weight word
//     img_rd_en      out  image buffer read strobe
//     img_rd_addr    out  raster pixel address
//     frame_start    out  frame begin pulse to conv engine
//     pixel_valid    out  pixel word valid to conv engine
//     out_stall      in   downstream full, pauses pixel reads
//     conv_valid     in   conv engine output strobe
//     out_count      out  outputs received during this pass
// ----------------------------------------------------------------------------
module conv_layer_ctrl
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH     = 8,
  parameter int IMG_HEIGHT    = 8,
  parameter int KERNEL_SIZE   = 3,
  parameter int IN_CHANNEL    = 3,
  parameter int NUM_FILTERS   = 3,
  parameter int STRIDE        = 1,
  parameter int PADDING       = (KERNEL_SIZE - 1) / 2,
  parameter int DRAIN_TIMEOUT = 1024,
  localparam int NW    = calc_nw(NUM_FILTERS, IN_CHANNEL, KERNEL_SIZE),
  localparam int NPIX  = calc_npix(IMG_WIDTH, IMG_HEIGHT),
  localparam int OUT_W = calc_out_dim(IMG_WIDTH, KERNEL_SIZE, PADDING, STRIDE),
  localparam int OUT_H = calc_out_dim(IMG_HEIGHT, KERNEL_SIZE, PADDING, STRIDE),
  localparam int NOUT  = OUT_W * OUT_H,
  localparam int WAW   = addr_width(NW),
  localparam int PAW   = addr_width(NPIX),
  localparam int CW    = addr_width(NOUT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic           wgt_rd_en,
  output logic [WAW-1:0] wgt_rd_addr,
  output logic           wgt_load_en,
  output logic           wgt_load_last,
  output logic           img_rd_en,
  output logic [PAW-1:0] img_rd_addr,
  output logic           frame_start,
  output logic           pixel_valid,
  input  logic           out_stall,
  input  logic           conv_valid,
  output logic [CW-1:0]  out_count
);

  localparam int              DW         = addr_width(DRAIN_TIMEOUT);
  localparam logic [CW-1:0]   NOUT_V     = CW'(NOUT);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

  state_t          state;
  logic            wgt_at_max;
  logic            pix_at_max;
  logic            start_accept;
  logic            cv_window;
  logic            cv_accept;
  logic            cv_overflow;
  logic [CW-1:0]   count_next;
  logic [DW-1:0]   drain_cnt;

  // Address generators; both are zeroed when a pass is accepted so a pass
  // aborted by reset or a previous odd run never leaks a stale address.
  conv_addr_counter #(
    .WIDTH (WAW),
    .MAX   (NW - 1)
  ) u_wgt_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_accept),
    .enable (wgt_rd_en),
    .count  (wgt_rd_addr),
    .at_max (wgt_at_max)
  );

  conv_addr_counter #(
    .WIDTH (PAW),
    .MAX   (NPIX - 1)
  ) u_pix_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_accept),
    .enable (img_rd_en),
    .count  (img_rd_addr),
    .at_max (pix_at_max)
  );

  assign busy         = (state != IDLE);
  assign start_accept = (state == IDLE) && start;

  // Pixel reads must react to back-pressure in the same cycle, so this
  // strobe is combinational. frame_start is high only in the first STREAM
  // cycle, which is exactly the cycle reads are held off.
  assign img_rd_en = (state == STREAM) && !frame_start && !out_stall;

  // Conv outputs only count while a pass is in flight; once the expected
  // total is reached any further strobe is a protocol fault.
  assign cv_window   = (state == LOAD_W) || (state == STREAM) || (state == DRAIN);
  assign cv_accept   = cv_window && conv_valid && (out_count != NOUT_V);
  assign cv_overflow = cv_window && conv_valid && (out_count == NOUT_V);
  assign count_next  = cv_accept ? out_count + 1'b1 : out_count;

  // Controller FSM. The memory-latency delay stages live here too so every
  // registered output shares one reset and one update point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wgt_rd_en     <= 1'b0;
      wgt_load_en   <= 1'b0;
      wgt_load_last <= 1'b0;
      pixel_valid   <= 1'b0;
      frame_start   <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      out_count     <= '0;
      drain_cnt     <= '0;
    end else begin
      wgt_load_en   <= wgt_rd_en;
      wgt_load_last <= wgt_rd_en && wgt_at_max;
      pixel_valid   <= img_rd_en;
      frame_start   <= 1'b0;
      done          <= 1'b0;
      out_count     <= count_next;
      if (cv_overflow) begin
        error <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD_W;
            wgt_rd_en <= 1'b1;
            error     <= 1'b0;
            out_count <= '0;
          end
        end

        LOAD_W: begin
          if (wgt_at_max) begin
            state       <= STREAM;
            wgt_rd_en   <= 1'b0;
            frame_start <= 1'b1;
          end
        end

        // The engine may already have returned everything by the last read
        // (e.g. it ran ahead during a stall), in which case DRAIN is skipped.
        STREAM: begin
          if (img_rd_en && pix_at_max) begin
            if (count_next == NOUT_V) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end

        // drain_cnt holds the number of DRAIN cycles already spent, so the
        // state is left after at most DRAIN_TIMEOUT cycles.
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (count_next == NOUT_V) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            error <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_conv_layer_ctrl
//   Self-checking bench for conv_layer_ctrl at default parameters.
//   Expected weight and pixel address sequences are queued when a pass is
//   started and popped as the DUT issues reads. A small conv-engine model
//   answers each pixel_valid with a conv_valid two cycles later, up to a
//   configurable budget.
// ----------------------------------------------------------------------------
module tb_conv_layer_ctrl;

  localparam int NW            = 81;
  localparam int NPIX          = 64;
  localparam int NOUT          = 64;
  localparam int DRAIN_TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       out_stall = 1'b0;
  logic       model_cv = 1'b0;
  logic       tb_cv = 1'b0;
  logic       conv_valid;
  logic       busy, done, error;
  logic       wgt_rd_en, wgt_load_en, wgt_load_last;
  logic [6:0] wgt_rd_addr;
  logic       img_rd_en, frame_start, pixel_valid;
  logic [5:0] img_rd_addr;
  logic [6:0] out_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assign conv_valid = model_cv | tb_cv;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  conv_layer_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .wgt_rd_en     (wgt_rd_en),
    .wgt_rd_addr   (wgt_rd_addr),
    .wgt_load_en   (wgt_load_en),
    .wgt_load_last (wgt_load_last),
    .img_rd_en     (img_rd_en),
    .img_rd_addr   (img_rd_addr),
    .frame_start   (frame_start),
    .pixel_valid   (pixel_valid),
    .out_stall     (out_stall),
    .conv_valid    (conv_valid),
    .out_count     (out_count)
  );

  // Conv engine model: fixed two-cycle latency from pixel_valid, limited to
  // model_budget outputs per pass.
  int         model_budget = 0;
  logic [1:0] pipe = 2'b00;

  always @(negedge clk) begin
    if (!rst_n) begin
      pipe     = 2'b00;
      model_cv = 1'b0;
    end else begin
      model_cv = 1'b0;
      if (pipe[1] && model_budget > 0) begin
        model_cv     = 1'b1;
        model_budget = model_budget - 1;
      end
      pipe = {pipe[0], pixel_valid};
    end
  end

  // Scoreboard and pass statistics, sampled mid-cycle.
  int   wgt_q[$];
  int   pix_q[$];
  int   exp_addr;
  logic prev_wrd = 1'b0;
  logic prev_ird = 1'b0;
  int   wload_cnt, last_cnt, last_idx, fs_cnt, pv_cnt, rd_cnt, done_cnt;
  int   done_cyc, last_rd_cyc;
  logic err_at_last_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wrd = 1'b0;
      prev_ird = 1'b0;
    end else begin
      checks++;
      if (wgt_load_en !== prev_wrd) begin
        failures++;
        $display("[TB] FAIL wgt_load_delay cyc=%0d: got %b expected %b", cyc, wgt_load_en, prev_wrd);
      end
      checks++;
      if (pixel_valid !== prev_ird) begin
        failures++;
        $display("[TB] FAIL pixel_valid_delay cyc=%0d: got %b expected %b", cyc, pixel_valid, prev_ird);
      end
      if (wgt_load_en === 1'b1) begin
        wload_cnt++;
        checks++;
        if (wgt_load_last !== (wload_cnt == NW)) begin
          failures++;
          $display("[TB] FAIL wgt_load_last word=%0d: got %b expected %b", wload_cnt, wgt_load_last, (wload_cnt == NW));
        end
        if (wgt_load_last === 1'b1) begin
          last_cnt++;
          last_idx = wload_cnt;
        end
      end else if (wgt_load_last !== 1'b0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wgt_load_last_alone cyc=%0d: got %b expected 0", cyc, wgt_load_last);
      end
      if (wgt_rd_en === 1'b1) begin
        checks++;
        if (wgt_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL wgt_rd_unexpected: got addr %0d expected no read", wgt_rd_addr);
        end else begin
          exp_addr = wgt_q.pop_front();
          if (wgt_rd_addr !== exp_addr[6:0]) begin
            failures++;
            $display("[TB] FAIL wgt_rd_addr: got %0d expected %0d", wgt_rd_addr, exp_addr);
          end
        end
      end
      if (img_rd_en === 1'b1) begin
        checks++;
        rd_cnt++;
        last_rd_cyc    = cyc;
        err_at_last_rd = error;
        if (pix_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL img_rd_unexpected: got addr %0d expected no read", img_rd_addr);
        end else begin
          exp_addr = pix_q.pop_front();
          if (img_rd_addr !== exp_addr[5:0] || out_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL img_rd_addr: got %0d (stall=%b) expected %0d (stall=0)", img_rd_addr, out_stall, exp_addr);
          end
        end
      end
      if (frame_start === 1'b1) begin
        fs_cnt++;
        checks++;
        if (img_rd_en !== 1'b0 || prev_wrd !== 1'b1) begin
          failures++;
          $display("[TB] FAIL frame_start_cycle: got rd_en=%b prev_wgt_rd=%b expected rd_en=0 prev_wgt_rd=1", img_rd_en, prev_wrd);
        end
      end
      if (pixel_valid === 1'b1) pv_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_wrd = wgt_rd_en;
      prev_ird = img_rd_en;
    end
  end

  function automatic logic [28:0] all_outputs();
    return {busy, done, error, wgt_rd_en, wgt_rd_addr, wgt_load_en, wgt_load_last,
            img_rd_en, img_rd_addr, frame_start, pixel_valid, out_count};
  endfunction

  task automatic clear_stats();
    wgt_q.delete();
    pix_q.delete();
    wload_cnt = 0; last_cnt = 0; last_idx = 0; fs_cnt = 0; pv_cnt = 0;
    rd_cnt = 0; done_cnt = 0; done_cyc = 0; last_rd_cyc = 0;
    err_at_last_rd = 1'b0;
  endtask

  task automatic load_scoreboard();
    for (int i = 0; i < NW; i++) wgt_q.push_back(i);
    for (int i = 0; i < NPIX; i++) pix_q.push_back(i);
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk); #1;
      n++;
      if (done_cnt > 0) seen = 1'b1;
    end
  endtask

  task automatic wait_read_addr(input int addr, input int budget, output bit found);
    int n;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      @(posedge clk); #2;
      n++;
      if (img_rd_en === 1'b1 && img_rd_addr == addr[5:0]) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    out_stall = 1'b0;
    tb_cv = 1'b0;
    model_budget = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (all_outputs() !== 29'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", all_outputs());
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || out_count !== 7'd0 || error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got busy=%b count=%0d err=%b expected 0 0 0", busy, out_count, error);
    end
  endtask

  task automatic test_basic_pass();
    bit seen;
    clear_stats();
    load_scoreboard();
    model_budget = NOUT;
    pulse_start();
    wait_done(600, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL basic_done_timeout: got no done expected done");
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (wload_cnt !== NW || last_cnt !== 1 || last_idx !== NW) begin
      failures++;
      $display("[TB] FAIL basic_weights: got loads=%0d lasts=%0d last_at=%0d expected %0d 1 %0d", wload_cnt, last_cnt, last_idx, NW, NW);
    end
    checks++;
    if (fs_cnt !== 1 || pv_cnt !== NPIX || rd_cnt !== NPIX) begin
      failures++;
      $display("[TB] FAIL basic_stream: got fs=%0d pv=%0d rd=%0d expected 1 %0d %0d", fs_cnt, pv_cnt, rd_cnt, NPIX, NPIX);
    end
    checks++;
    if (done_cnt !== 1 || out_count !== 7'(NOUT) || error !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_end: got done=%0d count=%0d err=%b busy=%b expected 1 %0d 0 0", done_cnt, out_count, error, busy, NOUT);
    end
    checks++;
    if (done_cyc - last_rd_cyc !== 4) begin
      failures++;
      $display("[TB] FAIL basic_drain_to_done: got %0d cycles expected 4", done_cyc - last_rd_cyc);
    end
    checks++;
    if (wgt_q.size() !== 0 || pix_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL basic_scoreboard_left: got %0d/%0d expected 0/0", wgt_q.size(), pix_q.size());
    end
    tb_cv = 1'b1;
    @(posedge clk); #2;
    tb_cv = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (out_count !== 7'(NOUT) || error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_conv_valid: got count=%0d err=%b expected %0d 0", out_count, error, NOUT);
    end
  endtask

  task automatic test_stall();
    bit seen;
    bit found;
    clear_stats();
    load_scoreboard();
    model_budget = NOUT;
    pulse_start();
    wait_read_addr(20, 400, found);
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL stall_reach_addr: got no read at 20 expected read");
    end
    out_stall = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      checks++;
      if (img_rd_en !== 1'b0 || img_rd_addr !== 6'd20) begin
        failures++;
        $display("[TB] FAIL stall_hold: got rd_en=%b addr=%0d expected 0 20", img_rd_en, img_rd_addr);
      end
    end
    @(posedge clk); #2;
    out_stall = 1'b0;
    wait_done(600, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL stall_done_timeout: got no done expected done");
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (pv_cnt !== NPIX || rd_cnt !== NPIX || pix_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL stall_pixels: got pv=%0d rd=%0d left=%0d expected %0d %0d 0", pv_cnt, rd_cnt, pix_q.size(), NPIX, NPIX);
    end
    checks++;
    if (out_count !== 7'(NOUT) || error !== 1'b0 || done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL stall_end: got count=%0d err=%b done=%0d expected %0d 0 1", out_count, error, done_cnt, NOUT);
    end
  endtask

  task automatic test_drain_timeout();
    bit seen;
    clear_stats();
    load_scoreboard();
    model_budget = 60;
    pulse_start();
    wait_done(1500, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL timeout_done_missing: got no done expected done");
    end
    checks++;
    if (error !== 1'b1 || err_at_last_rd !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_error: got err=%b err_before=%b expected 1 0", error, err_at_last_rd);
    end
    checks++;
    if (done_cyc - last_rd_cyc !== DRAIN_TIMEOUT + 1) begin
      failures++;
      $display("[TB] FAIL timeout_length: got %0d cycles expected %0d", done_cyc - last_rd_cyc, DRAIN_TIMEOUT + 1);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (out_count !== 7'd60 || done_cnt !== 1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_end: got count=%0d done=%0d busy=%b expected 60 1 0", out_count, done_cnt, busy);
    end
  endtask

  task automatic test_overflow();
    bit seen;
    bit found;
    clear_stats();
    load_scoreboard();
    model_budget = 63;
    pulse_start();
    wait_read_addr(63, 400, found);
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL overflow_reach_addr: got no read at 63 expected read");
    end
    out_stall = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (out_count !== 7'd63 || error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overflow_pre: got count=%0d err=%b expected 63 0", out_count, error);
    end
    tb_cv = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    tb_cv = 1'b0;
    checks++;
    if (out_count !== 7'(NOUT) || error !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow_flag: got count=%0d err=%b expected %0d 1", out_count, error, NOUT);
    end
    repeat (3) @(posedge clk);
    #2;
    out_stall = 1'b0;
    wait_done(20, seen);
    checks++;
    if (!seen || done_cyc - last_rd_cyc !== 1) begin
      failures++;
      $display("[TB] FAIL overflow_direct_done: got seen=%0d gap=%0d expected 1 1", seen, done_cyc - last_rd_cyc);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (out_count !== 7'(NOUT) || error !== 1'b1 || rd_cnt !== NPIX) begin
      failures++;
      $display("[TB] FAIL overflow_end: got count=%0d err=%b rd=%0d expected %0d 1 %0d", out_count, error, rd_cnt, NOUT, NPIX);
    end
  endtask

  task automatic test_restart_reset();
    bit seen;
    bit found;
    clear_stats();
    load_scoreboard();
    model_budget = NOUT;
    pulse_start();
    wait_read_addr(10, 400, found);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    checks++;
    if (!found || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL restart_busy: got found=%0d busy=%b expected 1 1", found, busy);
    end
    wait_read_addr(30, 400, found);
    checks++;
    if (!found || wload_cnt !== NW) begin
      failures++;
      $display("[TB] FAIL restart_ignored: got found=%0d loads=%0d expected 1 %0d", found, wload_cnt, NW);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== 29'd0) begin
      failures++;
      $display("[TB] FAIL midpass_reset: got %h expected 0", all_outputs());
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    clear_stats();
    load_scoreboard();
    model_budget = NOUT;
    pulse_start();
    wait_done(600, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL reset_rerun_timeout: got no done expected done");
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (wload_cnt !== NW || pv_cnt !== NPIX || fs_cnt !== 1 || done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL reset_rerun_counts: got loads=%0d pv=%0d fs=%0d done=%0d expected %0d %0d 1 1", wload_cnt, pv_cnt, fs_cnt, done_cnt, NW, NPIX);
    end
    checks++;
    if (out_count !== 7'(NOUT) || error !== 1'b0 || wgt_q.size() !== 0 || pix_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL reset_rerun_end: got count=%0d err=%b left=%0d/%0d expected %0d 0 0/0", out_count, error, wgt_q.size(), pix_q.size(), NOUT);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_stall();
    test_drain_timeout();
    test_overflow();
    test_restart_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected completion within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conv_layer_ctrl.md
CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
 - IMG_WIDTH, 8, input columns
 - IMG_HEIGHT, 8, input rows
 - KERNEL_SIZE, 3, kernel edge
 - IN_CHANNEL, 3, input channels
 - NUM_FILTERS, 3, output filters
 - STRIDE, 1, conv stride
 - PADDING, (KERNEL_SIZE-1)/2, zero padding
 - DRAIN_TIMEOUT, 1024, max DRAIN cycles
REQ-002 Derived constants SHALL be:
 - NW = NUM_FILTERS*IN_CHANNEL*KERNEL_SIZE^2
 - NPIX = IMG_WIDTH*IMG_HEIGHT
 - OUT_W = (IMG_WIDTH+2*PADDING-KERNEL_SIZE)/STRIDE+1
 - OUT_H likewise from IMG_HEIGHT
 - NOUT = OUT_W*OUT_H
REQ-003 Ports SHALL be (name, direction, width, meaning):
 - clk  in  1  single clock; reset is asynchronous and active-low
 - rst_n  in  1  async active-low reset
 - start  in  1  begin layer pass; sampled in IDLE only
 - busy  out  1  high in every state except IDLE
 - done  out  1  one-cycle pulse at pass end
 - error  out  1  sticky fault flag, cleared by accepted start
 - wgt_rd_en  out  1  weight memory read strobe
 - wgt_rd_addr  out  clog2(NW)  weight address
 - wgt_load_en  out  1  to conv: weight word valid
 - wgt_load_last  out  1  qualifies final weight word
 - img_rd_en  out  1  image buffer read strobe
 - img_rd_addr  out  clog2(NPIX)  raster pixel address
 - frame_start  out  1  to conv: frame begin pulse
 - pixel_valid  out  1  to conv: pixel word valid
 - out_stall  in  1  downstream full; pauses pixel reads
 - conv_valid  in  1  conv output strobe
 - out_count  out  clog2(NOUT+1)  outputs received this pass

Function
REQ-004 FSM states SHALL be IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-005 IDLE->LOAD_W on start; error, out_count and both addresses SHALL clear on that edge.
REQ-006 LOAD_W SHALL assert wgt_rd_en for exactly NW consecutive cycles, addr 0..NW-1; ->STREAM after addr NW-1.
REQ-007 Memories have 1-cycle read latency: wgt_load_en SHALL equal wgt_rd_en delayed 1 cycle; pixel_valid SHALL equal img_rd_en delayed 1 cycle.
REQ-008 wgt_load_last SHALL be high only with the wgt_load_en of word NW-1.
REQ-009 frame_start SHALL pulse for one cycle, the first STREAM cycle, and img_rd_en SHALL stay low that cycle.
REQ-010 In later STREAM cycles, img_rd_en SHALL equal !out_stall; addr increments only on a read; ->DRAIN after addr NPIX-1 is read.
REQ-011 conv_valid SHALL increment out_count in LOAD_W, STREAM and DRAIN, saturating at NOUT.
REQ-012 conv_valid arriving while out_count==NOUT SHALL set error.
REQ-013 DRAIN->DONE when out_count==NOUT (also when reached during STREAM, immediately after the last read).
REQ-014 DRAIN exceeding DRAIN_TIMEOUT cycles SHALL set error and ->DONE.
REQ-015 DONE SHALL last one cycle with done=1, then ->IDLE; out_count and error hold until next start.
REQ-016 start while busy SHALL be ignored.
REQ-017 conv_valid in IDLE/DONE SHALL be ignored.

Reset
REQ-018 rst_n low SHALL force IDLE immediately; all outputs, delay registers and counters 0, including mid-pass.

Structure
REQ-019 State encoding and the derived-constant functions SHALL live in shared package cnn_pkg.
REQ-020 One sub-module conv_addr_counter (enable, clear, wrap-at-max flag) SHALL be instantiated for the weight and pixel addresses.

Verification
REQ-021 Defaults, start pulse, no stall, model returns 64 conv_valid -> 81 wgt_load_en with last on #81, frame_start once, 64 pixel_valid, done once, out_count=64, error=0.
REQ-022 out_stall high for 5 cycles at pixel addr 20 -> no reads during stall, addresses contiguous, still 64 pixel_valid.
REQ-023 Model returns only 60 outputs -> error=1 and done pulse after 1024 DRAIN cycles.
REQ-024 65 conv_valid -> error=1, out_count=64.
REQ-025 start re-pulsed during STREAM -> ignored; rst_n asserted mid-STREAM -> busy=0, all outputs 0 same cycle; next start runs a clean pass.
